wdm_ring_lock_ctrl: RTL and testbench
=====================================

// Module: wdm_ring_lock_ctrl
// PURPOSE
//   Receive-side lock controller for one WDM drop-filter ring. It sweeps the ring heater code,
//   finds the code with maximum drop-port photodetector power, parks there, then dither-tracks
//   the peak. One instance per demux channel. It is the receive-end counterpart to the
//   multi-wavelength transmit bundle. The photonic model supplies a digitised power code.
// PARAMETERS
//   HEATER_W     8    heater DAC code width; sweep range 0..2^HEATER_W-1
//   PD_W         10   photodetector ADC code width (unsigned)
//   SETTLE_CYC   4    cycles to wait after every heater change before sampling (>=1)
//   LOCK_THRESH  64   minimum PD code for a valid peak or a held lock
// PORTS
//   clk             in   1         single clock
//   rst             in   1         asynchronous, active-high reset
//   i_start         in   1         pulse: begin acquisition (ignored unless in IDLE)
//   i_stop          in   1         pulse: abandon acquisition/tracking, return to IDLE
//   i_pd_valid      in   1         i_pd_code valid this cycle
//   i_pd_code       in   PD_W      drop-port power code
//   o_heater_code   out  HEATER_W  heater DAC code (registered)
//   o_busy          out  1         acquiring or tracking (high in any state but IDLE)
//   o_locked        out  1         in TRACK state
//   o_fail          out  1         last sweep found no peak >= LOCK_THRESH; sticky until next i_start
//   o_peak_code     out  HEATER_W  heater code of best sample from last sweep
//   o_peak_pd       out  PD_W      PD code at o_peak_code
// BEHAVIOUR
//   Reset (async, any state): all outputs 0; FSM=IDLE; settle counter 0.
//   States: IDLE, SW_SETTLE, SW_SAMPLE, PARK_SETTLE, TR_SETTLE, TR_SAMPLE.
//   Settle rule: every heater write loads counter=SETTLE_CYC. The *_SETTLE state decrements it and
//     exits when it reaches 0. i_pd_valid is ignored while settling. A *_SAMPLE state waits
//     indefinitely for i_pd_valid and consumes exactly one sample.
//   IDLE: on i_start & !i_stop: heater<=0, peak_code<=0, peak_pd<=0, fail<=0, busy<=1 -> SW_SETTLE.
//   SW_SAMPLE on valid: if pd > peak_pd (strict, so the lowest code wins ties), update peak_code/pd.
//     If heater != max: heater<=heater+1 -> SW_SETTLE.
//     If heater == max: evaluate with the updated peak. If peak_pd < LOCK_THRESH: fail<=1, heater<=0,
//     busy<=0 -> IDLE. Otherwise heater<=peak_code -> PARK_SETTLE -> TR_SETTLE (locked<=1).
//   TRACK cycle, 3 samples: centre c, then c+1, then c-1, each preceded by a settle.
//     After the 3rd sample: heater<=argmax(pc, pp, pm). Ties keep c; if pp==pm>pc choose c+1.
//     Then TR_SETTLE for the next cycle.
//     At c==max the +1 probe is skipped (pp=0); at c==0 the -1 probe is skipped (pm=0).
//     If centre sample pc < LOCK_THRESH: locked<=0, restart the sweep as from i_start (fail stays 0).
//   o_peak_code/o_peak_pd are updated only during a sweep, not during tracking.
//   i_stop in any non-IDLE state: next cycle FSM=IDLE, busy<=0, locked<=0, heater held.
//     i_stop has priority over i_start and over a same-cycle sample.
//   i_start while busy: ignored. Arithmetic is unsigned; heater never wraps.
//   Latency: first sweep sample is taken no earlier than SETTLE_CYC+1 cycles after i_start.
//     A full sweep takes >= 2^HEATER_W*(SETTLE_CYC+1) cycles.
// TESTING
//   1 Reset mid-sweep (heater=37): async rst -> all outputs 0 immediately; FSM IDLE; no re-sweep without i_start.
//   2 HEATER_W=4, PD model peaked at code 9 (pd=500, falling 40/code), i_pd_valid always 1: after
//     i_start -> 16 samples, peak_code=9, peak_pd=500, heater=9, locked=1, fail=0.
//   3 Flat PD=20 (<64): after the full sweep -> fail=1, busy=0, heater=0, locked=0.
//     A later i_start clears fail.
//   4 Locked at 9, model peak drifts to 10 (pd(10)=500, pd(9)=460): after one track cycle heater=10, locked stays 1.
//   5 Locked, PD drops to 0: locked falls after the centre sample, sweep restarts from heater=0, fail=0.
//   6 i_stop and i_start same cycle while IDLE -> remains IDLE. i_stop during SW_SAMPLE with valid
//     -> IDLE, peak not updated, heater held.
//   7 Edges: PD peaked at code 0 and at code 15 -> lock at edge; out-of-range probe skipped; heater never wraps.

Source files
------------

// File: rtl/wdm_ring_lock_ctrl.sv
// WDM drop-ring lock controller: sweeps the heater for peak drop power, parks on the peak,
// then dither-tracks it with centre / +1 / -1 probes.
module wdm_ring_lock_ctrl #(
  parameter int unsigned HEATER_W    = 8,
  parameter int unsigned PD_W        = 10,
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned LOCK_THRESH = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_pd_valid,
  input  logic [PD_W-1:0]     i_pd_code,
  output logic [HEATER_W-1:0] o_heater_code,
  output logic                o_busy,
  output logic                o_locked,
  output logic                o_fail,
  output logic [HEATER_W-1:0] o_peak_code,
  output logic [PD_W-1:0]     o_peak_pd
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0]    SETTLE_LOAD = CNT_W'(SETTLE_CYC);
  localparam logic [PD_W-1:0]     THRESH      = PD_W'(LOCK_THRESH);
  localparam logic [HEATER_W-1:0] HMAX        = '1;

  typedef enum logic [2:0] {
    StIdle, StSwSettle, StSwSample, StParkSettle, StTrSettle, StTrSample
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [HEATER_W-1:0] r_heater, w_heater_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_locked, w_locked_nxt;
  logic                r_fail, w_fail_nxt;
  logic [HEATER_W-1:0] r_peak_code, w_peak_code_nxt;
  logic [PD_W-1:0]     r_peak_pd, w_peak_pd_nxt;
  logic [HEATER_W-1:0] r_center, w_center_nxt;
  logic [1:0]          r_phase, w_phase_nxt;  // 0: centre, 1: +1 probe, 2: -1 probe
  logic [PD_W-1:0]     r_pc, w_pc_nxt;
  logic [PD_W-1:0]     r_pp, w_pp_nxt;

  logic                w_settle_done;
  logic [CNT_W-1:0]    w_cnt_dec;
  logic                w_sw_better;
  logic [HEATER_W-1:0] w_sw_pk_code;
  logic [PD_W-1:0]     w_sw_pk_pd;
  logic [PD_W-1:0]     w_pp_eff;
  logic [PD_W-1:0]     w_pm_eff;
  logic [HEATER_W-1:0] w_pick;
  logic                w_restart;

  assign w_settle_done = (r_cnt <= CNT_W'(1));
  assign w_cnt_dec     = (r_cnt != '0) ? r_cnt - CNT_W'(1) : '0;
  assign w_sw_better   = (i_pd_code > r_peak_pd);
  assign w_sw_pk_code  = w_sw_better ? r_heater : r_peak_code;
  assign w_sw_pk_pd    = w_sw_better ? i_pd_code : r_peak_pd;

  // Skipped probes read as zero power, so they can never win the argmax.
  always_comb begin
    w_pp_eff = (r_phase == 2'd1) ? i_pd_code : r_pp;
    w_pm_eff = (r_phase == 2'd2) ? i_pd_code : '0;
    w_pick   = r_center;
    if ((w_pp_eff > r_pc) && (w_pp_eff >= w_pm_eff) && (r_center != HMAX)) begin
      w_pick = r_center + 1'b1;
    end else if ((w_pm_eff > r_pc) && (w_pm_eff > w_pp_eff) && (r_center != '0)) begin
      w_pick = r_center - 1'b1;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_heater_nxt    = r_heater;
    w_busy_nxt      = r_busy;
    w_locked_nxt    = r_locked;
    w_fail_nxt      = r_fail;
    w_peak_code_nxt = r_peak_code;
    w_peak_pd_nxt   = r_peak_pd;
    w_center_nxt    = r_center;
    w_phase_nxt     = r_phase;
    w_pc_nxt        = r_pc;
    w_pp_nxt        = r_pp;
    w_restart       = 1'b0;

    if (i_stop && (r_state != StIdle)) begin
      w_state_nxt  = StIdle;
      w_busy_nxt   = 1'b0;
      w_locked_nxt = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start && !i_stop) w_restart = 1'b1;
        end
        StSwSettle: begin
          w_cnt_nxt = w_cnt_dec;
          if (w_settle_done) w_state_nxt = StSwSample;
        end
        StSwSample: begin
          if (i_pd_valid) begin
            w_peak_code_nxt = w_sw_pk_code;
            w_peak_pd_nxt   = w_sw_pk_pd;
            w_cnt_nxt       = SETTLE_LOAD;
            if (r_heater != HMAX) begin
              w_heater_nxt = r_heater + 1'b1;
              w_state_nxt  = StSwSettle;
            end else if (w_sw_pk_pd < THRESH) begin
              w_fail_nxt   = 1'b1;
              w_heater_nxt = '0;
              w_busy_nxt   = 1'b0;
              w_state_nxt  = StIdle;
            end else begin
              w_heater_nxt = w_sw_pk_code;
              w_state_nxt  = StParkSettle;
            end
          end
        end
        StParkSettle: begin
          w_cnt_nxt = w_cnt_dec;
          if (w_settle_done) begin
            w_locked_nxt = 1'b1;
            w_center_nxt = r_heater;
            w_phase_nxt  = 2'd0;
            w_cnt_nxt    = SETTLE_LOAD;
            w_state_nxt  = StTrSettle;
          end
        end
        StTrSettle: begin
          w_cnt_nxt = w_cnt_dec;
          if (w_settle_done) w_state_nxt = StTrSample;
        end
        StTrSample: begin
          if (i_pd_valid) begin
            w_cnt_nxt   = SETTLE_LOAD;
            w_state_nxt = StTrSettle;
            unique case (r_phase)
              2'd0: begin
                w_pc_nxt = i_pd_code;
                if (i_pd_code < THRESH) begin
                  w_locked_nxt = 1'b0;
                  w_restart    = 1'b1;
                end else if (r_center != HMAX) begin
                  w_heater_nxt = r_center + 1'b1;
                  w_phase_nxt  = 2'd1;
                end else begin
                  w_pp_nxt     = '0;
                  w_heater_nxt = r_center - 1'b1;
                  w_phase_nxt  = 2'd2;
                end
              end
              2'd1: begin
                w_pp_nxt = i_pd_code;
                if (r_center != '0) begin
                  w_heater_nxt = r_center - 1'b1;
                  w_phase_nxt  = 2'd2;
                end else begin
                  w_heater_nxt = w_pick;
                  w_center_nxt = w_pick;
                  w_phase_nxt  = 2'd0;
                end
              end
              default: begin
                w_heater_nxt = w_pick;
                w_center_nxt = w_pick;
                w_phase_nxt  = 2'd0;
              end
            endcase
          end
        end
        default: w_state_nxt = StIdle;
      endcase

      if (w_restart) begin
        w_heater_nxt    = '0;
        w_peak_code_nxt = '0;
        w_peak_pd_nxt   = '0;
        w_fail_nxt      = 1'b0;
        w_busy_nxt      = 1'b1;
        w_cnt_nxt       = SETTLE_LOAD;
        w_state_nxt     = StSwSettle;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_heater    <= '0;
      r_busy      <= 1'b0;
      r_locked    <= 1'b0;
      r_fail      <= 1'b0;
      r_peak_code <= '0;
      r_peak_pd   <= '0;
      r_center    <= '0;
      r_phase     <= 2'd0;
      r_pc        <= '0;
      r_pp        <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_heater    <= w_heater_nxt;
      r_busy      <= w_busy_nxt;
      r_locked    <= w_locked_nxt;
      r_fail      <= w_fail_nxt;
      r_peak_code <= w_peak_code_nxt;
      r_peak_pd   <= w_peak_pd_nxt;
      r_center    <= w_center_nxt;
      r_phase     <= w_phase_nxt;
      r_pc        <= w_pc_nxt;
      r_pp        <= w_pp_nxt;
    end
  end

  assign o_heater_code = r_heater;
  assign o_busy        = r_busy;
  assign o_locked      = r_locked;
  assign o_fail        = r_fail;
  assign o_peak_code   = r_peak_code;
  assign o_peak_pd     = r_peak_pd;

endmodule

// File: tb/tb_wdm_ring_lock_ctrl.sv
// Scoreboard bench for wdm_ring_lock_ctrl: expected snapshots are queued by the stimulus and
// popped by a monitor on every busy/locked/fail change or on an explicit probe request.
module tb_wdm_ring_lock_ctrl;

  localparam int unsigned HW = 4;
  localparam int unsigned PW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start = 1'b0;
  logic          i_stop = 1'b0;
  logic          i_pd_valid = 1'b1;
  logic [PW-1:0] i_pd_code;
  logic [HW-1:0] o_heater_code;
  logic          o_busy, o_locked, o_fail;
  logic [HW-1:0] o_peak_code;
  logic [PW-1:0] o_peak_pd;

  wdm_ring_lock_ctrl #(
    .HEATER_W(HW), .PD_W(PW), .SETTLE_CYC(4), .LOCK_THRESH(64)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop), .i_pd_valid(i_pd_valid),
    .i_pd_code(i_pd_code), .o_heater_code(o_heater_code), .o_busy(o_busy),
    .o_locked(o_locked), .o_fail(o_fail), .o_peak_code(o_peak_code), .o_peak_pd(o_peak_pd)
  );

  always #5 clk = ~clk;

  // Photonic model: 500 at the peak code, falling 40 per code, or a flat level.
  int pd_peak = 9;
  int pd_flat = 0;
  bit pd_flat_mode = 1'b0;
  int m_d, m_v;
  always_comb begin
    m_d = (int'(o_heater_code) > pd_peak) ? int'(o_heater_code) - pd_peak
                                          : pd_peak - int'(o_heater_code);
    m_v = 500 - 40 * m_d;
    if (m_v < 0) m_v = 0;
    i_pd_code = pd_flat_mode ? PW'(pd_flat) : PW'(m_v);
  end

  typedef struct {
    string         name;
    logic          busy, locked, fail;
    logic [HW-1:0] heater, pcode;
    logic [PW-1:0] ppd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   probe_pending = 1'b0;
  bit   watch_lo = 1'b0;
  bit   watch_hi = 1'b0;
  event ev_probe;

  task automatic push(input string n, input logic b, input logic l, input logic f,
                      input int h, input int pc, input int ppd);
    exp_t e;
    e.name = n; e.busy = b; e.locked = l; e.fail = f;
    e.heater = HW'(h); e.pcode = HW'(pc); e.ppd = PW'(ppd);
    q.push_back(e);
  endtask

  task automatic probe();
    #1;
    probe_pending = 1'b1;
    -> ev_probe;
  endtask

  // Monitor: pops one expectation per status change or probe request.
  initial begin : monitor
    logic [2:0] prev, cur;
    exp_t e;
    prev = 3'b000;
    forever begin
      @(negedge clk or ev_probe);
      cur = {o_busy, o_locked, o_fail};
      if (cur !== prev || probe_pending) begin
        probe_pending = 1'b0;
        prev = cur;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: busy/locked/fail=%b heater=%0d with no expectation",
                   cur, o_heater_code);
        end else begin
          e = q.pop_front();
          if (o_busy !== e.busy || o_locked !== e.locked || o_fail !== e.fail ||
              o_heater_code !== e.heater || o_peak_code !== e.pcode || o_peak_pd !== e.ppd) begin
            errors++;
            $display("FAIL %s: got b=%0d l=%0d f=%0d heater=%0d pk_code=%0d pk_pd=%0d, required b=%0d l=%0d f=%0d heater=%0d pk_code=%0d pk_pd=%0d",
                     e.name, o_busy, o_locked, o_fail, o_heater_code, o_peak_code, o_peak_pd,
                     e.busy, e.locked, e.fail, e.heater, e.pcode, e.ppd);
          end
        end
      end
    end
  end

  // Edge tracking must never leave the neighbourhood of the edge code.
  always @(negedge clk) begin
    if (watch_lo) begin
      checks++;
      if (o_heater_code > HW'(1)) begin
        errors++;
        $display("FAIL edge_lo_range: heater=%0d, required <= 1", o_heater_code);
      end
    end
    if (watch_hi) begin
      checks++;
      if (o_heater_code < HW'(14)) begin
        errors++;
        $display("FAIL edge_hi_range: heater=%0d, required >= 14", o_heater_code);
      end
    end
  end

  function automatic int sel_val(input int sel);
    case (sel)
      0:       return int'(o_heater_code);
      1:       return int'(o_busy);
      default: return int'(o_locked);
    endcase
  endfunction

  task automatic wait_for(input int sel, input int val, input string tag);
    int n;
    n = 0;
    while (sel_val(sel) != val && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: value=%0d, required %0d", tag, sel_val(sel), val);
    end
  endtask

  task automatic pulse(input bit st, input bit sp);
    @(posedge clk); #1;
    i_start = st; i_stop = sp;
    @(posedge clk); #1;
    i_start = 1'b0; i_stop = 1'b0;
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    push("reset_state", 0, 0, 0, 0, 0, 0);
    probe();

    // Reset mid-sweep
    push("t1_start", 1, 0, 0, 0, 0, 0);
    pulse(1, 0);
    wait_for(0, 7, "t1_heater7");
    @(posedge clk); #1 rst = 1'b1;
    push("t1_async_reset", 0, 0, 0, 0, 0, 0);
    probe();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (50) @(negedge clk);
    push("t1_no_resweep", 0, 0, 0, 0, 0, 0);
    probe();

    // Peaked sweep locks on code 9
    push("t2_start", 1, 0, 0, 0, 0, 0);
    push("t2_lock", 1, 1, 0, 9, 9, 500);
    pulse(1, 0);
    wait_for(2, 1, "t2_lock");
    repeat (40) @(negedge clk);

    // Peak drifts to 10: centre moves, peak outputs untouched
    pd_peak = 10;
    wait_for(0, 11, "t4_probe11");
    wait_for(0, 9, "t4_probe9");
    wait_for(0, 10, "t4_centre10");
    push("t4_track_drift", 1, 1, 0, 10, 9, 500);
    probe();

    // Power collapses: unlock, re-sweep from 0, then fail on an empty sweep
    push("t5_unlock", 1, 0, 0, 0, 0, 0);
    push("t5_resweep_fail", 0, 0, 1, 0, 0, 0);
    pd_flat = 0;
    pd_flat_mode = 1'b1;
    wait_for(2, 0, "t5_unlock");
    wait_for(1, 0, "t5_idle");

    // Flat sub-threshold sweep fails; the new start clears fail; lowest code wins the tie
    pd_flat = 20;
    push("t3_start_clears_fail", 1, 0, 0, 0, 0, 0);
    push("t3_fail", 0, 0, 1, 0, 0, 20);
    pulse(1, 0);
    wait_for(1, 1, "t3_busy");
    wait_for(1, 0, "t3_idle");

    // Start and stop together while idle
    pulse(1, 1);
    repeat (10) @(negedge clk);
    push("t6_start_stop_idle", 0, 0, 1, 0, 0, 20);
    probe();

    // Stop wins over a sample pending in SW_SAMPLE at heater 3
    pd_flat_mode = 1'b0;
    pd_peak = 9;
    push("t6_start", 1, 0, 0, 0, 0, 0);
    pulse(1, 0);
    wait_for(0, 3, "t6_heater3");
    i_pd_valid = 1'b0;
    repeat (20) @(negedge clk);
    push("t6_stop_in_sample", 0, 0, 0, 3, 2, 220);
    @(posedge clk); #1;
    i_stop = 1'b1; i_pd_valid = 1'b1;
    @(posedge clk); #1;
    i_stop = 1'b0;
    repeat (40) @(negedge clk);
    push("t6_stays_idle", 0, 0, 0, 3, 2, 220);
    probe();

    // Edge lock at code 0: -1 probe skipped
    pd_peak = 0;
    push("t7_lo_start", 1, 0, 0, 0, 0, 0);
    push("t7_lo_lock", 1, 1, 0, 0, 0, 500);
    pulse(1, 0);
    wait_for(2, 1, "t7_lo_lock");
    watch_lo = 1'b1;
    wait_for(0, 1, "t7_lo_probe1");
    wait_for(0, 0, "t7_lo_centre");
    push("t7_lo_track", 1, 1, 0, 0, 0, 500);
    probe();
    watch_lo = 1'b0;
    push("t7_lo_stop", 0, 0, 0, 0, 0, 500);
    pulse(0, 1);
    repeat (5) @(negedge clk);

    // Edge lock at code 15: +1 probe skipped
    pd_peak = 15;
    push("t7_hi_start", 1, 0, 0, 0, 0, 0);
    push("t7_hi_lock", 1, 1, 0, 15, 15, 500);
    pulse(1, 0);
    wait_for(2, 1, "t7_hi_lock");
    watch_hi = 1'b1;
    wait_for(0, 14, "t7_hi_probe14");
    wait_for(0, 15, "t7_hi_centre");
    push("t7_hi_track", 1, 1, 0, 15, 15, 500);
    probe();
    watch_hi = 1'b0;
    push("t7_hi_stop", 0, 0, 0, 15, 15, 500);
    pulse(0, 1);
    repeat (5) @(negedge clk);

    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: never observed, required b=%0d l=%0d f=%0d heater=%0d",
               e.name, e.busy, e.locked, e.fail, e.heater);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
